bloom_filter_str_window: RTL and testbench
==========================================

Name: bloom_filter_str_window

Overview:
- Front stage of the bloom filter engine. It sits between the Avalon-ST sink and the per-length hash engines.
- Takes 8-byte beats from the sink and, for every lane, builds the windows that end at that lane's byte, for every string length MIN_STR_SIZE..MAX_STR_SIZE.
- Carries MAX_STR_SIZE-1 bytes of history across beats within a packet.
- Emits one registered beat of windows plus a per-lane, per-length validity mask to the hash engines.

Parameters:
- BYTE_W, 8, bits per symbol
- AST_SINK_SYMBOLS, 8, symbols per sink beat
- MIN_STR_SIZE, 3, shortest string length searched
- MAX_STR_SIZE, 5, longest string length searched; must satisfy MIN_STR_SIZE <= MAX_STR_SIZE < 32
- SIZES_CNT, MAX_STR_SIZE-MIN_STR_SIZE+1, number of string lengths (derived)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- en_i  in  1  engine enable (CSR EN bit)
- ast_sink_data_i  in  AST_SINK_SYMBOLS*BYTE_W  beat data; symbol 0 (first in stream) at the MSBs
- ast_sink_valid_i  in  1  beat valid
- ast_sink_ready_o  out  1  beat accepted when valid&ready
- ast_sink_startofpacket_i  in  1  first beat of packet
- ast_sink_endofpacket_i  in  1  last beat of packet
- ast_sink_empty_i  in  3  count of unused symbols at the tail of the eop beat
- str_data_o  out  AST_SINK_SYMBOLS*MAX_STR_SIZE*BYTE_W  windows. Lane k occupies [k*MAX_STR_SIZE*BYTE_W +: MAX_STR_SIZE*BYTE_W]. Inside the lane, byte j (at offset j*BYTE_W) is the stream byte j positions before lane k's byte; j=0 is lane k's own byte.
- str_mask_o  out  AST_SINK_SYMBOLS*SIZES_CNT  bit k*SIZES_CNT+(L-MIN_STR_SIZE) is 1 when lane k's length-L window is complete and inside one packet
- str_sop_o  out  1  registered copy of sop
- str_eop_o  out  1  registered copy of eop
- str_valid_o  out  1  output beat valid
- str_ready_i  in  1  downstream ready

Behaviour:
- Reset: all outputs 0 except ast_sink_ready_o. History bytes are 0. The history counter hcnt is 0.
- Ready rule:
  - ast_sink_ready_o = !str_valid_o | str_ready_i while en_i=1.
  - ast_sink_ready_o is forced to 1 while en_i=0.
- Latency: an accepted beat appears on str_* on the next cycle, as a single register stage.
- str_valid_o:
  - Set on accept with en_i=1.
  - Cleared when str_ready_i=1 and there is no new accept.
  - While str_valid_o=1 and str_ready_i=0, every str_* output holds stable.
- History per packet:
  - hist holds the last MAX_STR_SIZE-1 accepted bytes.
  - hcnt counts valid history bytes and saturates at MAX_STR_SIZE-1.
  - On an accepted sop beat, history is treated as empty (hcnt_eff=0) for that beat. Otherwise hcnt_eff=hcnt.
- Lane validity on an eop beat: lane k is valid iff k < AST_SINK_SYMBOLS-ast_sink_empty_i. Otherwise all lanes are valid.
- Mask rule: mask[k][L]=1 iff lane k is valid and hcnt_eff+k+1 >= L.
  - Bytes of a window that reach before the packet start are don't-care, but must be driven from hist or 0 (never X).
- History update on accept:
  - Not eop: hist takes the last MAX_STR_SIZE-1 bytes of the concatenation hist_eff,beat. hcnt = min(hcnt_eff+8, MAX_STR_SIZE-1).
  - Eop: hcnt=0.
- Missing sop: a beat with no sop after eop starts a fresh packet with hcnt=0, which is implicit. No error.
- Repeated sop mid-packet: restarts history at that beat.
- en_i deassert:
  - Beats are dropped.
  - hcnt clears to 0 on the next cycle.
  - str_valid_o clears on the next cycle even if str_ready_i=0; the pending beat is discarded.
- ast_sink_empty_i is ignored on non-eop beats.
- Values >= AST_SINK_SYMBOLS on eop give an all-zero mask; the beat still passes with str_eop_o=1.
- Mid-operation rst_i: immediate return to reset state; partial packet lost.

Test Plan:
- Packet "abcdefghij": beat0 "abcdefgh" sop; beat1 "ij", eop, empty=6. Required response:
  - Beat0 mask per lane 0..7 (L5,L4,L3 bits) = 000,000,001,011,111,111,111,111.
  - Beat1 mask lanes 0,1 = 111; lanes 2..7 = 000.
  - Beat1 lane1 bytes j0..j4 = 'j','i','h','g','f'.
- Single 3-byte packet "xyz" (sop+eop, empty=5) -> only lane2 L3 bit set. Lane2 bytes j0..j2 = 'z','y','x'. Next packet starts with hcnt=0.
- Backpressure: str_ready_i=0 for 5 cycles while beats are offered -> ast_sink_ready_o=0, and str_* is held bit-identical. The single beat completes on release; no loss or duplication.
- sop asserted on beat1 of an open packet -> beat1 lanes 0,1 have mask 000, lane2 has 001. There is no carry-over from beat0.
- en_i dropped for 3 cycles mid-packet, then restored with a non-sop beat -> no output while disabled. The first beat after restore has lanes 0,1 = 000 and lane2 = 001.
- rst_i pulse asserted asynchronously with str_valid_o=1 -> str_valid_o=0 in the same cycle, before the next clock edge. The next packet behaves as if from power-up.

Source files
------------

// File: rtl/bloom_filter_str_window.sv
// Bloom filter front stage: builds, for every lane of an 8-byte beat, the
// byte windows that end at that lane for every searched string length,
// using MAX_STR_SIZE-1 bytes of history carried across beats of a packet.
// Produces one registered output beat of windows plus a per-lane,
// per-length validity mask for the hash engines.
module bloom_filter_str_window #(
   parameter int BYTE_W           = 8,
   parameter int AST_SINK_SYMBOLS = 8,
   parameter int MIN_STR_SIZE     = 3,
   parameter int MAX_STR_SIZE     = 5,
   parameter int SIZES_CNT        = MAX_STR_SIZE - MIN_STR_SIZE + 1
) (
   input  logic                                             clk_i,
   input  logic                                             rst_i,
   input  logic                                             en_i,
   input  logic [AST_SINK_SYMBOLS*BYTE_W-1:0]               ast_sink_data_i,
   input  logic                                             ast_sink_valid_i,
   output logic                                             ast_sink_ready_o,
   input  logic                                             ast_sink_startofpacket_i,
   input  logic                                             ast_sink_endofpacket_i,
   input  logic [2:0]                                       ast_sink_empty_i,
   output logic [AST_SINK_SYMBOLS*MAX_STR_SIZE*BYTE_W-1:0]  str_data_o,
   output logic [AST_SINK_SYMBOLS*SIZES_CNT-1:0]            str_mask_o,
   output logic                                             str_sop_o,
   output logic                                             str_eop_o,
   output logic                                             str_valid_o,
   input  logic                                             str_ready_i
);

   localparam int S      = AST_SINK_SYMBOLS;
   localparam int HIST   = MAX_STR_SIZE - 1;
   localparam int EXT    = HIST + S;
   localparam int HC_W   = $clog2(MAX_STR_SIZE);
   localparam int LANE_W = MAX_STR_SIZE * BYTE_W;

   // Sink beat with the bytes reordered so that index 0 is the first
   // stream byte (the sink puts symbol 0 at the MSBs).
   typedef struct packed {
      logic [S-1:0][BYTE_W-1:0] bytes;
      logic                     sop;
      logic                     eop;
      logic [2:0]               empty;
   } sink_beat_t;

   sink_beat_t                  beat;
   logic                        accept;
   logic [HIST-1:0][BYTE_W-1:0] hist;     // index HIST-1 is the newest byte
   logic [HC_W-1:0]             hcnt;
   logic [HC_W-1:0]             hcnt_eff;
   logic [HC_W-1:0]             hcnt_nxt;
   logic [EXT-1:0][BYTE_W-1:0]  ext;      // history followed by the beat, oldest first

   // Saturating history count after absorbing one full beat.
   function automatic logic [HC_W-1:0] sat_hcnt(input logic [HC_W-1:0] h);
      int sum;
      sum = int'(h) + S;
      return (sum >= HIST) ? HC_W'(HIST) : HC_W'(sum);
   endfunction

   // Unpack the sink bus into stream-ordered bytes.
   always_comb begin
      beat.sop   = ast_sink_startofpacket_i;
      beat.eop   = ast_sink_endofpacket_i;
      beat.empty = ast_sink_empty_i;
      for (int k = 0; k < S; k++)
         beat.bytes[k] = ast_sink_data_i[(S-1-k)*BYTE_W +: BYTE_W];
   end

   // Sink is always drained while disabled so upstream never stalls;
   // those beats are simply dropped.
   assign ast_sink_ready_o = !en_i || !str_valid_o || str_ready_i;
   assign accept           = en_i && ast_sink_valid_i && ast_sink_ready_o;

   // A sop beat ignores whatever history is left from an earlier packet.
   // The stale bytes still feed the window, they are just masked off.
   assign hcnt_eff = beat.sop ? '0 : hcnt;
   assign hcnt_nxt = sat_hcnt(hcnt_eff);
   assign ext      = {beat.bytes, hist};

   // History, count and output-beat control.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hist        <= '0;
         hcnt        <= '0;
         str_valid_o <= 1'b0;
         str_sop_o   <= 1'b0;
         str_eop_o   <= 1'b0;
      end else if (!en_i) begin
         hcnt        <= '0;
         str_valid_o <= 1'b0;
      end else if (accept) begin
         str_valid_o <= 1'b1;
         str_sop_o   <= beat.sop;
         str_eop_o   <= beat.eop;
         hist        <= ext[EXT-1:S];
         hcnt        <= beat.eop ? '0 : hcnt_nxt;
      end else if (str_ready_i) begin
         str_valid_o <= 1'b0;
      end
   end

   for (genvar k = 0; k < S; k++) begin : g_lane
      logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] win;
      logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] win_q;
      logic [SIZES_CNT-1:0]                msk;
      logic [SIZES_CNT-1:0]                msk_q;
      logic                                lane_ok;

      // Lanes past the last used symbol of an eop beat carry no data.
      assign lane_ok = !beat.eop || (k < S - int'(beat.empty));

      // Window byte j is the stream byte j positions before this lane.
      always_comb begin
         for (int j = 0; j < MAX_STR_SIZE; j++)
            win[j] = ext[HIST + k - j];
      end

      // A length-L window is complete once L bytes of this packet end here.
      always_comb begin
         for (int l = 0; l < SIZES_CNT; l++)
            msk[l] = lane_ok && (int'(hcnt_eff) + k + 1 >= l + MIN_STR_SIZE);
      end

      // Output register for this lane, loaded on every accepted beat.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            win_q <= '0;
            msk_q <= '0;
         end else if (accept) begin
            win_q <= win;
            msk_q <= msk;
         end
      end

      assign str_data_o[k*LANE_W +: LANE_W]       = win_q;
      assign str_mask_o[k*SIZES_CNT +: SIZES_CNT] = msk_q;
   end

endmodule

// File: tb/tb_bloom_filter_str_window.sv
// Directed bench for bloom_filter_str_window with default parameters
// (8 lanes, lengths 3..5, 5-byte windows per lane).
module tb_bloom_filter_str_window;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [63:0]  data;
   logic         valid;
   logic         ready;
   logic         sop;
   logic         eop;
   logic [2:0]   empty;
   logic [319:0] str_data;
   logic [23:0]  str_mask;
   logic         str_sop;
   logic         str_eop;
   logic         str_valid;
   logic         str_ready;

   int total = 0;
   int bad   = 0;

   bloom_filter_str_window dut (
      .clk_i                    (clk),
      .rst_i                    (rst),
      .en_i                     (en),
      .ast_sink_data_i          (data),
      .ast_sink_valid_i         (valid),
      .ast_sink_ready_o         (ready),
      .ast_sink_startofpacket_i (sop),
      .ast_sink_endofpacket_i   (eop),
      .ast_sink_empty_i         (empty),
      .str_data_o               (str_data),
      .str_mask_o               (str_mask),
      .str_sop_o                (str_sop),
      .str_eop_o                (str_eop),
      .str_valid_o              (str_valid),
      .str_ready_i              (str_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] beat(input string s);
      logic [63:0] d;
      d = '0;
      for (int i = 0; i < 8; i++)
         if (i < s.len()) d[(7-i)*8 +: 8] = s[i];
      return d;
   endfunction

   function automatic logic [7:0] lb(input int k, input int j);
      return str_data[(k*5+j)*8 +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat, clock it once, then drop valid.
   task automatic send(input string s, input logic s_sop, input logic s_eop, input logic [2:0] s_empty);
      data  = beat(s);
      sop   = s_sop;
      eop   = s_eop;
      empty = s_empty;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      sop   = 1'b0;
      eop   = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (str_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", str_valid); end
      total++; if (str_mask !== 24'h0) begin bad++; $display("FAIL rst_mask got=%h want=000000", str_mask); end
      total++; if (str_data !== 320'h0) begin bad++; $display("FAIL rst_data got=%h want=0", str_data); end
      total++; if ({str_sop, str_eop} !== 2'b00) begin bad++; $display("FAIL rst_sop_eop got=%b want=00", {str_sop, str_eop}); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ready); end
      tick();
      tick();
      rst = 1'b0;
      tick();
      total++; if (str_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b want=0", str_valid); end
   endtask

   task automatic test_two_beat_packet();
      string want;
      want = "jihgf";
      str_ready = 1'b1;
      // empty is non-zero on a non-eop beat and must be ignored
      send("abcdefgh", 1'b1, 1'b0, 3'd3);
      total++; if (str_valid !== 1'b1) begin bad++; $display("FAIL b0_valid got=%b want=1", str_valid); end
      total++; if ({str_sop, str_eop} !== 2'b10) begin bad++; $display("FAIL b0_sop_eop got=%b want=10", {str_sop, str_eop}); end
      total++; if (str_mask !== 24'hFFF640) begin bad++; $display("FAIL b0_mask got=%h want=fff640", str_mask); end
      total++; if (lb(4, 4) !== "a") begin bad++; $display("FAIL b0_lane4_j4 got=%h want=%h", lb(4, 4), 8'h61); end
      send("ij", 1'b0, 1'b1, 3'd6);
      total++; if ({str_sop, str_eop} !== 2'b01) begin bad++; $display("FAIL b1_sop_eop got=%b want=01", {str_sop, str_eop}); end
      total++; if (str_mask !== 24'h00003F) begin bad++; $display("FAIL b1_mask got=%h want=00003f", str_mask); end
      for (int j = 0; j < 5; j++) begin
         total++; if (lb(1, j) !== want[j]) begin bad++; $display("FAIL b1_lane1_j%0d got=%h want=%h", j, lb(1, j), want[j]); end
      end
      tick();
      total++; if (str_valid !== 1'b0) begin bad++; $display("FAIL b1_no_dup got=%b want=0", str_valid); end
   endtask

   task automatic test_short_packet();
      string want;
      want = "zyx";
      send("xyz", 1'b1, 1'b1, 3'd5);
      total++; if (str_mask !== 24'h000040) begin bad++; $display("FAIL xyz_mask got=%h want=000040", str_mask); end
      for (int j = 0; j < 3; j++) begin
         total++; if (lb(2, j) !== want[j]) begin bad++; $display("FAIL xyz_lane2_j%0d got=%h want=%h", j, lb(2, j), want[j]); end
      end
      // next packet arrives without sop: must still start with empty history
      send("abcdefgh", 1'b0, 1'b0, 3'd0);
      total++; if (str_mask !== 24'hFFF640) begin bad++; $display("FAIL nosop_mask got=%h want=fff640", str_mask); end
      send("ij", 1'b0, 1'b1, 3'd6);
      total++; if (str_mask !== 24'h00003F) begin bad++; $display("FAIL nosop_b1_mask got=%h want=00003f", str_mask); end
      tick();
   endtask

   task automatic test_backpressure();
      logic [319:0] snap_d;
      logic [23:0]  snap_m;
      str_ready = 1'b0;
      send("ABCDEFGH", 1'b1, 1'b0, 3'd0);
      total++; if (str_mask !== 24'hFFF640) begin bad++; $display("FAIL bp_b0_mask got=%h want=fff640", str_mask); end
      snap_d = str_data;
      snap_m = str_mask;
      data  = beat("IJKLMNOP");
      eop   = 1'b1;
      empty = 3'd0;
      valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         total++; if (ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d got=%b want=0", c, ready); end
         tick();
         total++; if (str_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c%0d got=%b want=1", c, str_valid); end
         total++; if ({str_sop, str_eop} !== 2'b10) begin bad++; $display("FAIL bp_sop_eop_c%0d got=%b want=10", c, {str_sop, str_eop}); end
         total++; if (str_data !== snap_d) begin bad++; $display("FAIL bp_data_hold_c%0d got=%h want=%h", c, str_data, snap_d); end
         total++; if (str_mask !== snap_m) begin bad++; $display("FAIL bp_mask_hold_c%0d got=%h want=%h", c, str_mask, snap_m); end
      end
      str_ready = 1'b1;
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", ready); end
      tick();
      valid = 1'b0;
      eop   = 1'b0;
      total++; if ({str_valid, str_sop, str_eop} !== 3'b101) begin bad++; $display("FAIL bp_b1_flags got=%b want=101", {str_valid, str_sop, str_eop}); end
      total++; if (str_mask !== 24'hFFFFFF) begin bad++; $display("FAIL bp_b1_mask got=%h want=ffffff", str_mask); end
      total++; if ({lb(0, 0), lb(0, 1), lb(0, 4)} !== {"I", "H", "E"}) begin bad++; $display("FAIL bp_b1_lane0 got=%h want=%h", {lb(0, 0), lb(0, 1), lb(0, 4)}, {"I", "H", "E"}); end
      tick();
      total++; if (str_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", str_valid); end
   endtask

   task automatic test_repeated_sop();
      send("abcdefgh", 1'b1, 1'b0, 3'd0);
      send("ijklmnop", 1'b1, 1'b1, 3'd0);
      total++; if (str_mask !== 24'hFFF640) begin bad++; $display("FAIL resop_mask got=%h want=fff640", str_mask); end
      total++; if ({lb(2, 0), lb(2, 2)} !== {"k", "i"}) begin bad++; $display("FAIL resop_lane2 got=%h want=%h", {lb(2, 0), lb(2, 2)}, {"k", "i"}); end
      tick();
   endtask

   task automatic test_enable_drop();
      str_ready = 1'b0;
      send("abcdefgh", 1'b1, 1'b0, 3'd0);
      total++; if (str_valid !== 1'b1) begin bad++; $display("FAIL en_pre_valid got=%b want=1", str_valid); end
      en    = 1'b0;
      data  = beat("qrstuvwx");
      valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (ready !== 1'b1) begin bad++; $display("FAIL en_off_ready_c%0d got=%b want=1", c, ready); end
         tick();
         total++; if (str_valid !== 1'b0) begin bad++; $display("FAIL en_off_valid_c%0d got=%b want=0", c, str_valid); end
      end
      valid     = 1'b0;
      en        = 1'b1;
      str_ready = 1'b1;
      send("ijklmnop", 1'b0, 1'b1, 3'd0);
      total++; if (str_valid !== 1'b1) begin bad++; $display("FAIL en_on_valid got=%b want=1", str_valid); end
      total++; if (str_mask !== 24'hFFF640) begin bad++; $display("FAIL en_on_mask got=%h want=fff640", str_mask); end
      tick();
   endtask

   task automatic test_async_reset();
      str_ready = 1'b0;
      send("abcdefgh", 1'b1, 1'b0, 3'd0);
      total++; if (str_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b want=1", str_valid); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (str_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", str_valid); end
      total++; if (str_mask !== 24'h0) begin bad++; $display("FAIL ar_mask got=%h want=000000", str_mask); end
      total++; if (str_data !== 320'h0) begin bad++; $display("FAIL ar_data got=%h want=0", str_data); end
      #1;
      rst       = 1'b0;
      str_ready = 1'b1;
      send("abcdefgh", 1'b0, 1'b0, 3'd0);
      total++; if (str_mask !== 24'hFFF640) begin bad++; $display("FAIL ar_after_mask got=%h want=fff640", str_mask); end
      send("ij", 1'b0, 1'b1, 3'd6);
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      en        = 1'b1;
      data      = '0;
      valid     = 1'b0;
      sop       = 1'b0;
      eop       = 1'b0;
      empty     = 3'd0;
      str_ready = 1'b1;
      test_reset();
      test_two_beat_packet();
      test_short_packet();
      test_backpressure();
      test_repeated_sop();
      test_enable_drop();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
